// File: rtl/witf.sv
// Write-in-flight table: in-order scoreboard of destination registers between
// decode and writeback, providing RAW hazard detection for the decode stage.
module witf #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            disp_en,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            commit_en,
  input  logic [4:0]      commit_rd,
  input  logic            flush,
  output logic            isRAW,
  output logic            witf_full,
  output logic [PTRW:0]   count,
  output logic [1:0]      err
);

  localparam logic [PTRW:0] FULL_CNT = (PTRW + 1)'(DEPTH);

  logic [4:0]       rd_mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTRW-1:0]  head_q;
  logic [PTRW-1:0]  tail_q;
  logic [PTRW:0]    count_q;
  logic [1:0]       err_q;

  logic do_push;
  logic do_pop;
  logic push_err;
  logic pop_err;
  logic head_mismatch;
  logic empty;

  assign witf_full     = (count_q == FULL_CNT);
  assign empty         = (count_q == '0);
  assign head_mismatch = (commit_rd != rd_mem[head_q]);

  // Fullness is the registered state, so a pop never frees room for a same-cycle push.
  assign do_push  = disp_en & ~witf_full & ~flush;
  assign do_pop   = commit_en & ~empty & ~flush;
  assign push_err = disp_en & witf_full & ~flush;
  assign pop_err  = commit_en & ~flush & (empty | head_mismatch);

  assign count = count_q;
  assign err   = err_q;

  // Stored register numbers are only meaningful under their valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) rd_mem[tail_q] <= rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) begin
          valid_q[tail_q] <= 1'b1;
          tail_q          <= tail_q + PTRW'(1);
        end
        if (do_pop) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + PTRW'(1);
        end
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + (PTRW + 1)'(1);
          2'b01:   count_q <= count_q - (PTRW + 1)'(1);
          default: count_q <= count_q;
        endcase
      end
      if (push_err) err_q[0] <= 1'b1;
      if (pop_err)  err_q[1] <= 1'b1;
    end
  end

  // x0 never creates a hazard, so zero source fields are masked out.
  always_comb begin
    isRAW = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] &&
          (((rs1 != 5'd0) && (rs1 == rd_mem[i])) ||
           ((rs2 != 5'd0) && (rs2 == rd_mem[i]))))
        isRAW = 1'b1;
    end
  end

endmodule

// File: tb/tb_witf.sv
// Self-checking bench for witf: table of per-cycle vectors with a scoreboard of
// expected post-edge state, plus a hand-written asynchronous reset sequence.
module tb_witf;

  typedef struct {
    logic       de;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       ce;
    logic [4:0] crd;
    logic       fl;
    logic       raw;
    logic [2:0] cnt;
    logic       full;
    logic [1:0] err;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       disp_en;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       commit_en;
  logic [4:0] commit_rd;
  logic       flush;
  logic       isRAW;
  logic       witf_full;
  logic [2:0] count;
  logic [1:0] err;

  int checks;
  int failures;

  vec_t vecs[$];
  vec_t sb[$];

  witf #(.DEPTH(4), .PTRW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_en   (disp_en),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .commit_en (commit_en),
    .commit_rd (commit_rd),
    .flush     (flush),
    .isRAW     (isRAW),
    .witf_full (witf_full),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic de, input logic [4:0] rdv,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic ce, input logic [4:0] crd,
                              input logic fl, input logic raw,
                              input logic [2:0] cnt, input logic full,
                              input logic [1:0] e);
    vec_t v;
    v.de = de; v.rd = rdv; v.rs1 = r1; v.rs2 = r2; v.ce = ce; v.crd = crd;
    v.fl = fl; v.raw = raw; v.cnt = cnt; v.full = full; v.err = e;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector away from the active edge; isRAW reflects pre-edge state.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    disp_en = v.de; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    commit_en = v.ce; commit_rd = v.crd; flush = v.fl;
    #1;
    checkVal($sformatf("isRAW[%0d]", idx), {7'd0, isRAW}, {7'd0, v.raw});
    sb.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      checkVal($sformatf("count[%0d]", idx), {5'd0, count}, {5'd0, e.cnt});
      checkVal($sformatf("full[%0d]", idx), {7'd0, witf_full}, {7'd0, e.full});
      checkVal($sformatf("err[%0d]", idx), {6'd0, err}, {6'd0, e.err});
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; disp_en = 1'b0; rd = '0; rs1 = 5'd5; rs2 = 5'd6;
    commit_en = 1'b0; commit_rd = '0; flush = 1'b0;

    //           de rd  rs1 rs2 ce crd fl raw cnt full err
    vecs.push_back(mk(0, 0,  5,  6, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5,  0,  0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  5,  0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0,  5, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0,  6,  6, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  5,  0, 1, 5, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  5,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  0,  0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 2,  0,  0, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 3,  0,  0, 0, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 4,  4,  0, 0, 0, 0, 0, 4, 1, 0));
    vecs.push_back(mk(1, 7,  4,  0, 0, 0, 0, 1, 4, 1, 1));
    vecs.push_back(mk(1, 9,  1,  0, 1, 1, 0, 1, 3, 0, 1));
    vecs.push_back(mk(1, 8,  9,  0, 0, 0, 0, 0, 4, 1, 1));
    vecs.push_back(mk(0, 0,  8,  0, 1, 2, 0, 1, 3, 0, 1));
    vecs.push_back(mk(0, 0,  0,  0, 1, 3, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0,  0,  0, 1, 4, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,  8, 1, 8, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 3,  0,  0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 9,  0,  0, 0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(1, 10, 10, 0, 1, 3, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0,  3,  0, 0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0,  10, 0, 0, 0, 0, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0,  0,  0, 1, 9, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,  0, 1, 10, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0,  0,  0, 1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 4,  0,  0, 0, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0,  4,  0, 1, 6, 0, 1, 0, 0, 3));
    vecs.push_back(mk(0, 0,  4,  0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 0,  0,  0, 0, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(1, 12, 0,  0, 0, 0, 0, 0, 2, 0, 3));
    vecs.push_back(mk(1, 13, 0,  0, 0, 0, 0, 0, 3, 0, 3));
    vecs.push_back(mk(1, 14, 12, 0, 1, 0, 1, 1, 0, 0, 3));
    vecs.push_back(mk(0, 0,  14, 13, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 20, 0,  0, 0, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(1, 21, 20, 0, 0, 0, 0, 1, 2, 0, 3));

    // Reset held for two cycles, released away from the clock edge.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal("reset_count", {5'd0, count}, 8'd0);
    checkVal("reset_full", {7'd0, witf_full}, 8'd0);
    checkVal("reset_isRAW", {7'd0, isRAW}, 8'd0);
    checkVal("reset_err", {6'd0, err}, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
      checkOutput(i);
    end

    // Asynchronous reset mid-cycle must clear state without a clock edge.
    @(negedge clk);
    disp_en = 1'b0; commit_en = 1'b0; flush = 1'b0; rs1 = 5'd20; rs2 = 5'd21;
    #1;
    checkVal("pre_async_isRAW", {7'd0, isRAW}, 8'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkVal("async_count", {5'd0, count}, 8'd0);
    checkVal("async_isRAW", {7'd0, isRAW}, 8'd0);
    checkVal("async_err", {6'd0, err}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    disp_en = 1'b1; rd = 5'd17; rs1 = 5'd17; rs2 = 5'd0;
    @(posedge clk);
    #1;
    disp_en = 1'b0;
    checkVal("post_reset_count", {5'd0, count}, 8'd1);
    checkVal("post_reset_isRAW", {7'd0, isRAW}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
